// File: rtl/spart_tx_word.sv
// spart_tx_word: sends a 32-bit word on txd as NUM_BYTES back-to-back 8N1 frames, LSB byte first.
// Define SPART_TX_PARITY_EN to insert an even-parity bit after the data bits (11-bit frames).
module spart_tx_word #(
    parameter int CLK_DIV   = 2604,
    parameter int NUM_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tx_word,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        txd,
    output logic        busy,
    output logic        byte_sent
);

    localparam int               CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [1:0]       BYTE_LAST = 2'(NUM_BYTES - 1);

`ifdef SPART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic [1:0]       byte_idx, byte_idx_nx;
    logic [31:0]      shreg;
    logic [7:0]       cur_byte;
    logic             load, shift8, bit_done;
    logic             txd_nx, byte_sent_nx;

    assign tx_ready = (state == IDLE);
    assign busy     = ~tx_ready;
    assign cur_byte = shreg[7:0];
    assign bit_done = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            txd       <= 1'b1;
            byte_sent <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_idx   <= bit_idx_nx;
            byte_idx  <= byte_idx_nx;
            txd       <= txd_nx;
            byte_sent <= byte_sent_nx;
        end
    end

    // Payload register carries no reset; it is only meaningful after a handshake loads it.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= tx_word;
        end else if (shift8) begin
            shreg <= {8'h00, shreg[31:8]};
        end
    end

    // txd is registered from the current state, so the line lags the FSM by one cycle.
    always_comb begin
        state_nx     = state;
        cnt_nx       = bit_done ? '0 : cnt + CNT_W'(1);
        bit_idx_nx   = bit_idx;
        byte_idx_nx  = byte_idx;
        txd_nx       = 1'b1;
        byte_sent_nx = 1'b0;
        load         = 1'b0;
        shift8       = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (tx_valid) begin
                    load        = 1'b1;
                    byte_idx_nx = '0;
                    bit_idx_nx  = '0;
                    state_nx    = START;
                end
            end
            START: begin
                txd_nx = 1'b0;
                if (bit_done) begin
                    bit_idx_nx = '0;
                    state_nx   = DATA;
                end
            end
            DATA: begin
                txd_nx = cur_byte[bit_idx];
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
`ifdef SPART_TX_PARITY_EN
            PARITY: begin
                txd_nx = ^cur_byte;
                if (bit_done) begin
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    byte_sent_nx = 1'b1;
                    if (byte_idx != BYTE_LAST) begin
                        byte_idx_nx = byte_idx + 2'd1;
                        shift8      = 1'b1;
                        state_nx    = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spart_tx_word.sv
// Directed bench for spart_tx_word: CLK_DIV=16, one 4-byte and one 1-byte instance.
// Line timing: handshake at edge n, start bit occupies edges n+1 .. n+1+D, last stop ends at edge n+1+nb*FB*D.
module tb_spart_tx_word;

    localparam int D = 16;
`ifdef SPART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] w1 = '0, w2 = '0;
    logic        v1 = 1'b0, v2 = 1'b0;
    logic        r1, r2, t1, t2, b1, b2, s1, s2;

    int cyc = 0;
    int ncmp = 0;
    int nfail = 0;
    int q1[$];
    int q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s1) q1.push_back(cyc);
        if (s2) q2.push_back(cyc);
    end

    spart_tx_word #(.CLK_DIV(D), .NUM_BYTES(4)) dut (
        .clk(clk), .rst(rst), .tx_word(w1), .tx_valid(v1), .tx_ready(r1),
        .txd(t1), .busy(b1), .byte_sent(s1)
    );

    spart_tx_word #(.CLK_DIV(D), .NUM_BYTES(1)) dut1b (
        .clk(clk), .rst(rst), .tx_word(w2), .tx_valid(v2), .tx_ready(r2),
        .txd(t2), .busy(b2), .byte_sent(s2)
    );

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    function automatic logic line(input int sel);
        return (sel != 0) ? t2 : t1;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel != 0) ? r2 : r1;
    endfunction

    // Present a word, return n = index of the handshake edge (caller is at the negedge after it).
    task automatic hs(input int sel, input logic [31:0] w, input bit keep, output int n);
        @(negedge clk);
        if (sel != 0) begin w2 = w; v2 = 1'b1; q2.delete(); end
        else          begin w1 = w; v1 = 1'b1; q1.delete(); end
        @(posedge clk);
        @(negedge clk);
        n = cyc;
        if (!keep) begin
            if (sel != 0) v2 = 1'b0; else v1 = 1'b0;
        end
        ncmp++;
        if (rdy(sel) !== 1'b0) begin
            nfail++;
            $display("FAIL hs_ready_low: got %b expected 0", rdy(sel));
        end
    endtask

    task automatic check_word(input int sel, input int n, input int nb, input logic [31:0] w, input string nm);
        logic [7:0] exp_b, got_b;
        int base, e, qs;
        for (int j = 0; j < nb; j++) begin
            exp_b = w[8*j +: 8];
            got_b = '0;
            base = n + 1 + j*FB*D + D/2;
            wait_to(base);
            ncmp++;
            if (line(sel) !== 1'b0) begin
                nfail++;
                $display("FAIL %s_start%0d: got %b expected 0", nm, j, line(sel));
            end
            for (int k = 0; k < 8; k++) begin
                wait_to(base + (k+1)*D);
                got_b[k] = line(sel);
            end
            ncmp++;
            if (got_b !== exp_b) begin
                nfail++;
                $display("FAIL %s_byte%0d: got %h expected %h", nm, j, got_b, exp_b);
            end
`ifdef SPART_TX_PARITY_EN
            wait_to(base + 9*D);
            ncmp++;
            if (line(sel) !== ^exp_b) begin
                nfail++;
                $display("FAIL %s_parity%0d: got %b expected %b", nm, j, line(sel), ^exp_b);
            end
`endif
            wait_to(base + (FB-1)*D);
            ncmp++;
            if (line(sel) !== 1'b1) begin
                nfail++;
                $display("FAIL %s_stop%0d: got %b expected 1", nm, j, line(sel));
            end
        end
        e = n + nb*FB*D;
        wait_to(e - 1);
        ncmp++;
        if (rdy(sel) !== 1'b0) begin
            nfail++;
            $display("FAIL %s_ready_before_end: got %b expected 0", nm, rdy(sel));
        end
        wait_to(e);
        ncmp++;
        if (rdy(sel) !== 1'b1 || line(sel) !== 1'b1) begin
            nfail++;
            $display("FAIL %s_idle_at_end: got ready=%b txd=%b expected 1 1", nm, rdy(sel), line(sel));
        end
        @(negedge clk);
        qs = (sel != 0) ? q2.size() : q1.size();
        ncmp++;
        if (qs != nb) begin
            nfail++;
            $display("FAIL %s_byte_sent_count: got %0d expected %0d", nm, qs, nb);
        end else begin
            for (int j = 0; j < nb; j++) begin
                int got_c;
                got_c = (sel != 0) ? q2[j] : q1[j];
                ncmp++;
                if (got_c != n + (j+1)*FB*D) begin
                    nfail++;
                    $display("FAIL %s_byte_sent_time%0d: got %0d expected %0d", nm, j, got_c - n, (j+1)*FB*D);
                end
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        repeat (3) @(negedge clk);
        ncmp++;
        if (t1 !== 1'b1 || r1 !== 1'b1 || b1 !== 1'b0 || s1 !== 1'b0) begin
            nfail++;
            $display("FAIL reset_held: got txd=%b ready=%b busy=%b sent=%b expected 1 1 0 0", t1, r1, b1, s1);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (t1 !== 1'b1 || r1 !== 1'b1 || b1 !== 1'b0 || s1 !== 1'b0 ||
                t2 !== 1'b1 || r2 !== 1'b1 || b2 !== 1'b0 || s2 !== 1'b0) bad++;
        end
        ncmp++;
        if (bad != 0) begin
            nfail++;
            $display("FAIL reset_idle_500: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_word();
        int n;
        hs(0, 32'hA5C3_0F81, 1'b0, n);
        ncmp++;
        if (t1 !== 1'b1 || b1 !== 1'b1) begin
            nfail++;
            $display("FAIL word_after_hs: got txd=%b busy=%b expected 1 1", t1, b1);
        end
        wait_to(n + 1);
        ncmp++;
        if (t1 !== 1'b0) begin
            nfail++;
            $display("FAIL word_start_edge: got %b expected 0", t1);
        end
        check_word(0, n, 4, 32'hA5C3_0F81, "word");
    endtask

    task automatic test_back_to_back();
        int n, n2;
        hs(0, 32'h0000_0001, 1'b1, n);
        w1 = 32'hFFFF_FFFF;
        check_word(0, n, 4, 32'h0000_0001, "b2b_first");
        ncmp++;
        if (r1 !== 1'b0 || t1 !== 1'b1) begin
            nfail++;
            $display("FAIL b2b_gap: got ready=%b txd=%b expected 0 1", r1, t1);
        end
        n2 = cyc;
        v1 = 1'b0;
        w1 = 32'h0000_0000;
        q1.delete();
        wait_to(n2 + 1);
        ncmp++;
        if (t1 !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_second_start: got %b expected 0", t1);
        end
        check_word(0, n2, 4, 32'hFFFF_FFFF, "b2b_second");
    endtask

    task automatic test_reset_mid_frame();
        int n, bad;
        hs(0, 32'hA5C3_0F81, 1'b0, n);
        wait_to(n + 1 + (2*FB + 4)*D + D/2);
        ncmp++;
        if (t1 !== 1'b0) begin
            nfail++;
            $display("FAIL midrst_pre: got %b expected 0", t1);
        end
        #1 rst = 1'b1;
        v1 = 1'b1;
        w1 = 32'hDEAD_BEEF;
        #1;
        ncmp++;
        if (t1 !== 1'b1 || r1 !== 1'b1 || b1 !== 1'b0) begin
            nfail++;
            $display("FAIL midrst_async: got txd=%b ready=%b busy=%b expected 1 1 0", t1, r1, b1);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        v1 = 1'b0;
        q1.delete();
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (t1 !== 1'b1 || r1 !== 1'b1) bad++;
        end
        ncmp++;
        if (bad != 0 || q1.size() != 0) begin
            nfail++;
            $display("FAIL midrst_idle_after: got %0d bad cycles, %0d pulses expected 0 0", bad, q1.size());
        end
        hs(0, 32'h1234_5678, 1'b0, n);
        check_word(0, n, 4, 32'h1234_5678, "after_rst");
    endtask

    task automatic test_one_byte();
        int n, bad;
        hs(1, 32'hDEAD_BE55, 1'b0, n);
        check_word(1, n, 1, 32'hDEAD_BE55, "one_byte");
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (t2 !== 1'b1 || r2 !== 1'b1) bad++;
        end
        ncmp++;
        if (bad != 0 || q2.size() != 1) begin
            nfail++;
            $display("FAIL one_byte_quiet: got %0d bad cycles, %0d pulses expected 0 1", bad, q2.size());
        end
    endtask

`ifdef SPART_TX_PARITY_EN
    task automatic test_parity();
        int n;
        hs(1, 32'h0000_0007, 1'b0, n);
        check_word(1, n, 1, 32'h0000_0007, "parity_07");
        hs(1, 32'h0000_0003, 1'b0, n);
        check_word(1, n, 1, 32'h0000_0003, "parity_03");
    endtask
`endif

    initial begin
        test_reset();
        test_word();
        test_back_to_back();
        test_reset_mid_frame();
        test_one_byte();
`ifdef SPART_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
